gene_attractor_finder: RTL and testbench



---
 rtl/gene_attractor_finder_if.sv | 28 ++
 rtl/gene_attractor_finder.sv | 144 ++++++++++++++
 tb/tb_gene_attractor_finder.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gene_attractor_finder_if.sv
// Start/done handshake and result bus between the run controller and whoever launches runs.
// start/seed are a single-cycle request: the finder takes them only when idle and answers
// with one done pulse; there is no backpressure, so start simply stays high until taken.
interface gene_attractor_finder_if #(
  parameter int PER_W  = 5,
  parameter int STEP_W = 8
);
  logic              start;
  logic [7:0]        seed;
  logic              busy;
  logic              done;
  logic              found;
  logic [7:0]        cur_state;
  logic [7:0]        attractor_state;
  logic [PER_W-1:0]  period;
  logic [STEP_W-1:0] transient;
  logic [1:0]        fsm_state;

  modport master (
    output start, seed,
    input  busy, done, found, cur_state, attractor_state, period, transient, fsm_state
  );

  modport slave (
    input  start, seed,
    output busy, done, found, cur_state, attractor_state, period, transient, fsm_state
  );
endinterface

// File: rtl/gene_attractor_finder.sv
// Run controller for the 8-gene Boolean network: steps from a seed, keeps a sliding
// window of recent states and reports the first revisited state as the attractor.
module gene_attractor_finder #(
  parameter int HIST_DEPTH = 16,
  parameter int MAX_STEPS  = 255,
  parameter int STEP_W     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  gene_attractor_finder_if.slave bus
);

  localparam int PER_W = $clog2(HIST_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t              state;
  logic [7:0]          hist [HIST_DEPTH];
  logic [HIST_DEPTH-1:0] valid;
  logic [STEP_W-1:0]   steps;

  logic                busy_q;
  logic                done_q;
  logic                found_q;
  logic [7:0]          cur_q;
  logic [7:0]          attr_q;
  logic [PER_W-1:0]    per_q;
  logic [STEP_W-1:0]   trans_q;

  logic [7:0]          nxt;
  logic                hit;
  logic [PER_W-1:0]    hit_k;
  logic [7:0]          hit_state;

  function automatic logic [7:0] net_update(input logic [7:0] c);
    logic [7:0] n;
    n[0] = ~c[2] & c[6] & ~c[7];
    n[1] = (c[4] | c[5]) & ~c[7];
    n[2] = c[7];
    n[3] = c[1] & ~c[6];
    n[4] = c[1] | c[3];
    n[5] = c[2] & ~c[7];
    n[6] = c[1] & ~c[7];
    n[7] = ~(c[0] | c[1]) & (c[3] | c[6]);
    return n;
  endfunction

  // Scan from oldest to newest so the newest matching entry (smallest k) wins.
  always_comb begin
    nxt       = net_update(cur_q);
    hit       = 1'b0;
    hit_k     = '0;
    hit_state = '0;
    for (int k = HIST_DEPTH - 1; k >= 0; k--) begin
      if (valid[k] && (hist[k] == nxt)) begin
        hit       = 1'b1;
        hit_k     = PER_W'(k);
        hit_state = hist[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      valid   <= '0;
      steps   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      found_q <= 1'b0;
      cur_q   <= '0;
      attr_q  <= '0;
      per_q   <= '0;
      trans_q <= '0;
      for (int k = 0; k < HIST_DEPTH; k++) hist[k] <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            cur_q   <= bus.seed;
            hist[0] <= bus.seed;
            valid   <= HIST_DEPTH'(1);
            steps   <= '0;
            found_q <= 1'b0;
            per_q   <= '0;
            trans_q <= '0;
            attr_q  <= '0;
            busy_q  <= 1'b1;
            state   <= SEARCH;
          end
        end

        SEARCH: begin
          if (hit) begin
            found_q <= 1'b1;
            per_q   <= hit_k + PER_W'(1);
            trans_q <= steps - STEP_W'(hit_k);
            attr_q  <= hit_state;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state   <= DONE;
          end else if (steps == STEP_W'(MAX_STEPS - 1)) begin
            found_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state   <= DONE;
          end else begin
            // Sliding window: oldest entry falls off the end once the window is full.
            for (int k = HIST_DEPTH - 1; k >= 1; k--) begin
              hist[k]  <= hist[k-1];
              valid[k] <= valid[k-1];
            end
            hist[0]  <= nxt;
            valid[0] <= 1'b1;
            cur_q    <= nxt;
            steps    <= steps + STEP_W'(1);
          end
        end

        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.found           = found_q;
  assign bus.cur_state       = cur_q;
  assign bus.attractor_state = attr_q;
  assign bus.period          = per_q;
  assign bus.transient       = trans_q;
  assign bus.fsm_state       = state;

endmodule

// File: tb/tb_gene_attractor_finder.sv
// Bench for gene_attractor_finder: directed table, hand-written corner sequences and
// random seeds checked against a trajectory-list reference model, on three parameterisations.
module tb_gene_attractor_finder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  gene_attractor_finder_if #(.PER_W(5), .STEP_W(8)) bus_a ();
  gene_attractor_finder_if #(.PER_W(5), .STEP_W(8)) bus_b ();
  gene_attractor_finder_if #(.PER_W(1), .STEP_W(8)) bus_c ();

  gene_attractor_finder u_dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  gene_attractor_finder #(.HIST_DEPTH(16), .MAX_STEPS(4), .STEP_W(8))
    u_dut_b (.clk(clk), .reset(reset), .bus(bus_b));
  gene_attractor_finder #(.HIST_DEPTH(1), .MAX_STEPS(20), .STEP_W(8))
    u_dut_c (.clk(clk), .reset(reset), .bus(bus_c));

  int sel = 0;
  int errors = 0;
  int checks = 0;

  logic       m_busy, m_done, m_found;
  logic [7:0] m_cur, m_attr, m_per, m_trans;
  logic [1:0] m_fsm;

  always_comb begin
    m_busy = bus_a.busy; m_done = bus_a.done; m_found = bus_a.found;
    m_cur = bus_a.cur_state; m_attr = bus_a.attractor_state;
    m_per = 8'(bus_a.period); m_trans = bus_a.transient; m_fsm = bus_a.fsm_state;
    if (sel == 1) begin
      m_busy = bus_b.busy; m_done = bus_b.done; m_found = bus_b.found;
      m_cur = bus_b.cur_state; m_attr = bus_b.attractor_state;
      m_per = 8'(bus_b.period); m_trans = bus_b.transient; m_fsm = bus_b.fsm_state;
    end else if (sel == 2) begin
      m_busy = bus_c.busy; m_done = bus_c.done; m_found = bus_c.found;
      m_cur = bus_c.cur_state; m_attr = bus_c.attractor_state;
      m_per = 8'(bus_c.period); m_trans = bus_c.transient; m_fsm = bus_c.fsm_state;
    end
  end

  typedef struct {
    logic [7:0] seed;
    logic       fnd;
    logic [7:0] per;
    logic [7:0] trans;
    logic [7:0] attr;
    logic [7:0] cur;
    int         lat;
  } vec_t;

  vec_t tbl [6];

  // Reference model: network rule written per gene, trajectory kept as a plain list.
  function automatic logic [7:0] gene_step(input logic [7:0] s);
    logic [7:0] r;
    r = 8'h00;
    if (!s[2] && s[6] && !s[7])            r = r | 8'h01;
    if ((s[4] || s[5]) && !s[7])           r = r | 8'h02;
    if (s[7])                              r = r | 8'h04;
    if (s[1] && !s[6])                     r = r | 8'h08;
    if (s[1] || s[3])                      r = r | 8'h10;
    if (s[2] && !s[7])                     r = r | 8'h20;
    if (s[1] && !s[7])                     r = r | 8'h40;
    if (!(s[0] || s[1]) && (s[3] || s[6])) r = r | 8'h80;
    return r;
  endfunction

  task automatic model_run(input logic [7:0] seed, input int h, input int m, output vec_t v);
    logic [7:0] traj [$];
    logic [7:0] nx;
    int lo;
    traj.push_back(seed);
    v.seed = seed; v.fnd = 1'b0; v.per = 0; v.trans = 0; v.attr = 0; v.cur = seed; v.lat = m + 1;
    for (int step = 0; step < m; step++) begin
      nx = gene_step(traj[$]);
      lo = (traj.size() > h) ? traj.size() - h : 0;
      for (int j = traj.size() - 1; j >= lo; j--) begin
        if (traj[j] == nx) begin
          v.fnd = 1'b1; v.per = 8'(traj.size() - j); v.trans = 8'(j);
          v.attr = traj[j]; v.cur = traj[$]; v.lat = step + 2;
          return;
        end
      end
      if (step == m - 1) begin
        v.cur = traj[$];
        return;
      end
      traj.push_back(nx);
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_start(input int s, input logic v, input logic [7:0] sd);
    case (s)
      1:       begin bus_b.start = v; bus_b.seed = sd; end
      2:       begin bus_c.start = v; bus_c.seed = sd; end
      default: begin bus_a.start = v; bus_a.seed = sd; end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called one step after a rising edge with the selected DUT idle.
  task automatic run_check(input string tag, input int s, input vec_t e);
    int lat, busy_cnt;
    sel = s;
    set_start(s, 1'b1, e.seed);
    tick();
    set_start(s, 1'b0, e.seed);
    lat = 1;
    busy_cnt = 0;
    while (!m_done && lat < 400) begin
      if (m_busy) busy_cnt++;
      tick();
      lat++;
    end
    check({tag, " latency"}, lat, e.lat);
    check({tag, " found"}, m_found, e.fnd);
    check({tag, " period"}, m_per, e.per);
    check({tag, " transient"}, m_trans, e.trans);
    check({tag, " attractor"}, m_attr, e.attr);
    check({tag, " cur_state"}, m_cur, e.cur);
    check({tag, " busy cycles"}, busy_cnt, e.lat - 1);
    check({tag, " busy at done"}, m_busy, 1'b0);
    tick();
    check({tag, " done pulse"}, m_done, 1'b0);
    check({tag, " hold found"}, m_found, e.fnd);
  endtask

  initial begin
    vec_t v;
    int lat, pulses;
    logic [7:0] rs;

    tbl[0] = '{8'h00, 1'b1, 8'd1, 8'd0, 8'h00, 8'h00, 2};
    tbl[1] = '{8'h80, 1'b1, 8'd2, 8'd6, 8'h1C, 8'hB2, 9};
    tbl[2] = '{8'h04, 1'b1, 8'd2, 8'd5, 8'h1C, 8'hB2, 8};
    tbl[3] = '{8'h1C, 1'b1, 8'd2, 8'd0, 8'h1C, 8'hB2, 3};
    tbl[4] = '{8'hB2, 1'b1, 8'd2, 8'd0, 8'hB2, 8'h1C, 3};
    tbl[5] = '{8'h58, 1'b1, 8'd2, 8'd2, 8'h1C, 8'hB2, 5};

    reset = 1'b1;
    set_start(0, 1'b0, 8'h00);
    set_start(1, 1'b0, 8'h00);
    set_start(2, 1'b0, 8'h00);
    repeat (3) tick();
    reset = 1'b0;
    tick();

    sel = 0;
    check("reset busy", m_busy, 1'b0);
    check("reset done", m_done, 1'b0);
    check("reset found", m_found, 1'b0);
    check("reset cur_state", m_cur, 8'h00);
    check("reset period", m_per, 8'h00);
    check("reset fsm", m_fsm, 2'd0);

    for (int i = 0; i < 6; i++) begin
      run_check($sformatf("tbl%0d", i), 0, tbl[i]);
      repeat ($urandom_range(0, 2)) tick();
    end

    v = '{8'h80, 1'b0, 8'd0, 8'd0, 8'h00, 8'h02, 5};
    run_check("budget4", 1, v);
    v = '{8'h80, 1'b0, 8'd0, 8'd0, 8'h00, 8'hB2, 21};
    run_check("depth1", 2, v);

    // Reset in the middle of a run: no done, everything cleared, next run normal.
    sel = 0;
    set_start(0, 1'b1, 8'h80);
    tick();
    set_start(0, 1'b0, 8'h80);
    repeat (3) tick();
    check("midrun busy before reset", m_busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort busy", m_busy, 1'b0);
    check("abort done", m_done, 1'b0);
    check("abort cur_state", m_cur, 8'h00);
    check("abort fsm", m_fsm, 2'd0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (m_done) pulses++;
      tick();
    end
    check("abort no done", pulses, 0);
    run_check("after abort", 0, tbl[0]);

    // start held high with a wandering seed; second run seeded in the IDLE cycle after done.
    sel = 0;
    set_start(0, 1'b1, 8'h80);
    tick();
    lat = 1;
    while (!m_done && lat < 400) begin
      set_start(0, 1'b1, 8'($urandom_range(0, 255)));
      tick();
      lat++;
    end
    check("hold latency", lat, 9);
    check("hold found", m_found, 1'b1);
    check("hold period", m_per, 8'd2);
    check("hold transient", m_trans, 8'd6);
    check("hold attractor", m_attr, 8'h1C);
    set_start(0, 1'b1, 8'h1C);
    tick();
    check("hold idle after done", m_fsm, 2'd0);
    check("hold busy in idle", m_busy, 1'b0);
    set_start(0, 1'b1, 8'h00);
    tick();
    set_start(0, 1'b0, 8'h00);
    check("rerun busy", m_busy, 1'b1);
    tick();
    check("rerun done", m_done, 1'b1);
    check("rerun period", m_per, 8'd1);
    check("rerun attractor", m_attr, 8'h00);
    tick();

    for (int i = 0; i < 30; i++) begin
      rs = 8'($urandom_range(0, 255));
      model_run(rs, 16, 255, v);
      run_check($sformatf("rnd_a %0h", rs), 0, v);
      repeat ($urandom_range(0, 2)) tick();
    end
    for (int i = 0; i < 10; i++) begin
      rs = 8'($urandom_range(0, 255));
      model_run(rs, 16, 4, v);
      run_check($sformatf("rnd_b %0h", rs), 1, v);
    end
    for (int i = 0; i < 10; i++) begin
      rs = 8'($urandom_range(0, 255));
      model_run(rs, 1, 20, v);
      run_check($sformatf("rnd_c %0h", rs), 2, v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
